// File: rtl/register_file.sv
// Register bank: one write port, two registered read ports with
// write-first bypass, optional hard-wired zero entry and read-valid flags.
module register_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_port1,
    input  logic              read_en1,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic              read_en2,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [WIDTH-1:0]  read_port1,
    output logic [WIDTH-1:0]  read_port2,
    output logic              read_valid1,
    output logic              read_valid2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             wr_ok;
    logic             zero1, zero2;

    assign wr_ok = write_en && !(HAS_ZERO && write_addr == '0);
    assign zero1 = HAS_ZERO && read_addr1 == '0;
    assign zero2 = HAS_ZERO && read_addr2 == '0;

    // Zero entry wins over bypass, bypass wins over stored data.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        v1_d  = read_en1;
        v2_d  = read_en2;
        if (read_en1) begin
            if (zero1)
                rd1_d = '0;
            else if (write_en && write_addr == read_addr1)
                rd1_d = write_port1;
            else
                rd1_d = mem_q[read_addr1];
        end
        if (read_en2) begin
            if (zero2)
                rd2_d = '0;
            else if (write_en && write_addr == read_addr2)
                rd2_d = write_port1;
            else
                rd2_d = mem_q[read_addr2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            rd1_q <= '0;
            rd2_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
        end else begin
            if (wr_ok)
                mem_q[write_addr] <= write_port1;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
        end
    end

    assign read_port1  = rd1_q;
    assign read_port2  = rd2_q;
    assign read_valid1 = v1_q;
    assign read_valid2 = v2_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: vector table, zero-register sequence,
// random traffic vs. an array model, and a 32x32 streaming run.
module tb_register_file;

    logic clk;
    logic rst;

    logic        n_we;
    logic [2:0]  n_wa;
    logic [15:0] n_wd;
    logic        n_re1, n_re2;
    logic [2:0]  n_ra1, n_ra2;

    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_v1, a_v2, b_v1, b_v2;

    logic        w_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic        w_re1, w_re2;
    logic [4:0]  w_ra1, w_ra2;
    logic [31:0] w_rd1, w_rd2;
    logic        w_v1, w_v2;

    int tests;
    int fails;

    register_file #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst),
        .write_en(n_we), .write_addr(n_wa), .write_port1(n_wd),
        .read_en1(n_re1), .read_addr1(n_ra1),
        .read_en2(n_re2), .read_addr2(n_ra2),
        .read_port1(a_rd1), .read_port2(a_rd2),
        .read_valid1(a_v1), .read_valid2(a_v2)
    );

    register_file #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst),
        .write_en(n_we), .write_addr(n_wa), .write_port1(n_wd),
        .read_en1(n_re1), .read_addr1(n_ra1),
        .read_en2(n_re2), .read_addr2(n_ra2),
        .read_port1(b_rd1), .read_port2(b_rd2),
        .read_valid1(b_v1), .read_valid2(b_v2)
    );

    register_file #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) u_w (
        .clk(clk), .rst(rst),
        .write_en(w_we), .write_addr(w_wa), .write_port1(w_wd),
        .read_en1(w_re1), .read_addr1(w_ra1),
        .read_en2(w_re2), .read_addr2(w_ra2),
        .read_port1(w_rd1), .read_port2(w_rd2),
        .read_valid1(w_v1), .read_valid2(w_v2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = no zero register, 1 = zero register.
    logic [15:0] mn [2][8];
    logic [15:0] en1 [2];
    logic [15:0] en2 [2];
    logic        ev1 [2];
    logic        ev2 [2];
    logic [31:0] mw [32];
    logic [31:0] ew1, ew2;
    logic        evw1, evw2;

    function automatic logic [15:0] nread(int z, logic [2:0] a);
        if (z == 1 && a == 3'd0) return 16'h0;
        if (n_we && n_wa == a) return n_wd;
        return mn[z][a];
    endfunction

    function automatic logic [31:0] wread(logic [4:0] a);
        if (w_we && w_wa == a) return w_wd;
        return mw[a];
    endfunction

    task automatic model_step();
        for (int z = 0; z < 2; z++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) mn[z][k] = 16'h0;
                en1[z] = 16'h0; en2[z] = 16'h0;
                ev1[z] = 1'b0;  ev2[z] = 1'b0;
            end else begin
                if (n_re1) en1[z] = nread(z, n_ra1);
                if (n_re2) en2[z] = nread(z, n_ra2);
                ev1[z] = n_re1;
                ev2[z] = n_re2;
                if (n_we && !(z == 1 && n_wa == 3'd0)) mn[z][n_wa] = n_wd;
            end
        end
        if (rst) begin
            for (int k = 0; k < 32; k++) mw[k] = 32'h0;
            ew1 = 32'h0; ew2 = 32'h0; evw1 = 1'b0; evw2 = 1'b0;
        end else begin
            if (w_re1) ew1 = wread(w_ra1);
            if (w_re2) ew2 = wread(w_ra2);
            evw1 = w_re1;
            evw2 = w_re2;
            if (w_we) mw[w_wa] = w_wd;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("a.rd1", 32'(a_rd1), 32'(en1[0]));
        chk("a.rd2", 32'(a_rd2), 32'(en2[0]));
        chk("a.v1",  32'(a_v1),  32'(ev1[0]));
        chk("a.v2",  32'(a_v2),  32'(ev2[0]));
        chk("b.rd1", 32'(b_rd1), 32'(en1[1]));
        chk("b.rd2", 32'(b_rd2), 32'(en2[1]));
        chk("b.v1",  32'(b_v1),  32'(ev1[1]));
        chk("b.v2",  32'(b_v2),  32'(ev2[1]));
        chk("w.rd1", w_rd1, ew1);
        chk("w.rd2", w_rd2, ew2);
        chk("w.v1",  32'(w_v1), 32'(evw1));
        chk("w.v2",  32'(w_v2), 32'(evw2));
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        re1;
        logic [2:0]  ra1;
        logic        re2;
        logic [2:0]  ra2;
        logic [15:0] e1;
        logic        ev1;
        logic [15:0] e2;
        logic        ev2;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int r, int we, int wa, int wd,
                                int re1, int ra1, int re2, int ra2,
                                int e1, int v1, int e2, int v2);
        vec_t v;
        v.rst = r[0];     v.we  = we[0];
        v.wa  = wa[2:0];  v.wd  = wd[15:0];
        v.re1 = re1[0];   v.ra1 = ra1[2:0];
        v.re2 = re2[0];   v.ra2 = ra2[2:0];
        v.e1  = e1[15:0]; v.ev1 = v1[0];
        v.e2  = e2[15:0]; v.ev2 = v2[0];
        tbl.push_back(v);
    endfunction

    task automatic idle_all();
        rst = 1'b0;
        n_we = 1'b0; n_wa = 3'd0; n_wd = 16'h0;
        n_re1 = 1'b0; n_ra1 = 3'd0; n_re2 = 1'b0; n_ra2 = 3'd0;
        w_we = 1'b0; w_wa = 5'd0; w_wd = 32'h0;
        w_re1 = 1'b0; w_ra1 = 5'd0; w_re2 = 1'b0; w_ra2 = 5'd0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_all();

        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 1; a < 8; a++)
            add(0, 1, a, 'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 1; a < 8; a++)
            add(0, 0, 0, 0, 1, a, 1, a, 0, 1, 0, 1);
        add(0, 1, 3, 'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 'h1234, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h1234, 0, 0, 0);
        add(0, 1, 5, 'h0001, 0, 0, 0, 0, 'h1234, 0, 0, 0);
        add(0, 1, 4, 'h4444, 1, 5, 0, 0, 'h0001, 1, 0, 0);
        add(0, 1, 5, 'hA5A5, 1, 5, 1, 5, 'hA5A5, 1, 'hA5A5, 1);
        add(0, 1, 5, 'h5A5A, 1, 5, 1, 4, 'h5A5A, 1, 'h4444, 1);
        add(0, 1, 0, 'hFFFF, 0, 0, 1, 0, 'h5A5A, 0, 'hFFFF, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 'hFFFF, 1, 'hFFFF, 0);
        add(0, 1, 2, 'h2222, 0, 0, 0, 0, 'hFFFF, 0, 'hFFFF, 0);
        add(0, 0, 0, 0, 1, 2, 0, 0, 'h2222, 1, 'hFFFF, 0);
        add(1, 1, 2, 'h7777, 1, 2, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 2, 1, 3, 0, 1, 0, 1);
        add(0, 1, 6, 'h6666, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 6, 0, 0, 'h6666, 1, 0, 0);
        add(1, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst   = tbl[i].rst;
            n_we  = tbl[i].we;  n_wa  = tbl[i].wa;  n_wd = tbl[i].wd;
            n_re1 = tbl[i].re1; n_ra1 = tbl[i].ra1;
            n_re2 = tbl[i].re2; n_ra2 = tbl[i].ra2;
            cycle();
            chk($sformatf("vec%0d.rd1", i), 32'(a_rd1), 32'(tbl[i].e1));
            chk($sformatf("vec%0d.v1", i),  32'(a_v1),  32'(tbl[i].ev1));
            chk($sformatf("vec%0d.rd2", i), 32'(a_rd2), 32'(tbl[i].e2));
            chk($sformatf("vec%0d.v2", i),  32'(a_v2),  32'(tbl[i].ev2));
        end

        // Zero register: write to entry 0 with a concurrent read of it.
        idle_all();
        n_we = 1'b1; n_wa = 3'd0; n_wd = 16'hFFFF;
        n_re2 = 1'b1; n_ra2 = 3'd0;
        cycle();
        chk("zero.b.rd2", 32'(b_rd2), 32'h0);
        chk("zero.a.rd2", 32'(a_rd2), 32'hFFFF);
        idle_all();
        n_re1 = 1'b1; n_ra1 = 3'd0;
        cycle();
        chk("zero.b.rd1", 32'(b_rd1), 32'h0);
        chk("zero.b.v1",  32'(b_v1),  32'h1);
        chk("zero.a.rd1", 32'(a_rd1), 32'hFFFF);

        // Random traffic on the 16-bit banks.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            n_we  = 1'($urandom_range(0, 1));
            n_wa  = 3'($urandom_range(0, 7));
            n_wd  = 16'($urandom);
            n_re1 = ($urandom_range(0, 3) != 0);
            n_ra1 = 3'($urandom_range(0, 7));
            n_re2 = ($urandom_range(0, 3) != 0);
            n_ra2 = ($urandom_range(0, 3) == 0) ? n_wa
                                                : 3'($urandom_range(0, 7));
            cycle();
        end

        // Wide bank: seed entries, then stream reads of every address.
        idle_all();
        w_we = 1'b1; w_wa = 5'd31; w_wd = 32'hDEADBEEF;
        cycle();
        w_wa = 5'd0; w_wd = 32'h1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            w_wa = 5'($urandom_range(1, 30));
            w_wd = $urandom;
            cycle();
        end
        for (int a = 0; a < 32; a++) begin
            w_we  = ($urandom_range(0, 3) == 0);
            w_wa  = 5'($urandom_range(1, 30));
            w_wd  = $urandom;
            w_re1 = 1'b1;
            w_ra1 = 5'(a);
            w_re2 = 1'($urandom_range(0, 1));
            w_ra2 = 5'($urandom_range(0, 31));
            cycle();
            chk($sformatf("stream%0d.v1", a), 32'(w_v1), 32'h1);
            if (a == 0)  chk("stream.addr0",  w_rd1, 32'h1);
            if (a == 31) chk("stream.addr31", w_rd1, 32'hDEADBEEF);
        end
        idle_all();
        cycle();
        chk("stream.end.v1", 32'(w_v1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
